// File: rtl/div_iter_if.sv
// div_iter_if: dividend/divisor slave channels and the result master channel of the divider.
interface div_iter_if;
    logic        s_axis_dividend_tvalid;
    logic        s_axis_dividend_tready;
    logic [31:0] s_axis_dividend_tdata;
    logic        s_axis_divisor_tvalid;
    logic        s_axis_divisor_tready;
    logic [31:0] s_axis_divisor_tdata;
    logic        m_axis_dout_tvalid;
    logic [63:0] m_axis_dout_tdata;
    modport master (
        output s_axis_dividend_tvalid, s_axis_dividend_tdata,
        output s_axis_divisor_tvalid, s_axis_divisor_tdata,
        input  s_axis_dividend_tready, s_axis_divisor_tready,
        input  m_axis_dout_tvalid, m_axis_dout_tdata
    );
    modport slave (
        input  s_axis_dividend_tvalid, s_axis_dividend_tdata,
        input  s_axis_divisor_tvalid, s_axis_divisor_tdata,
        output s_axis_dividend_tready, s_axis_divisor_tready,
        output m_axis_dout_tvalid, m_axis_dout_tdata
    );
endinterface

// File: rtl/div_iter.sv
// div_iter: iterative 32-bit radix-2 restoring divider, result {quotient, remainder}.
// Optional DIV_ZERO_BYPASS_EN: a zero divisor skips the iterations and answers in cycle 1.
module div_iter #(
    parameter bit SIGNED = 1'b1
) (
    input logic       clk,
    input logic       reset,
    div_iter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;
    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [32:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic        q_neg_q, q_neg_d;
    logic        r_neg_q, r_neg_d;
    logic        dz_q, dz_d;
    logic [63:0] dout_q, dout_d;
    logic        accept;
    logic [33:0] shifted, diff;
    logic [31:0] dvd_in, dvs_in, q_fix, r_fix;
    assign accept = state_q == IDLE && bus.s_axis_dividend_tvalid && bus.s_axis_divisor_tvalid;
    assign dvd_in = bus.s_axis_dividend_tdata;
    assign dvs_in = bus.s_axis_divisor_tdata;
    assign bus.s_axis_dividend_tready = state_q == IDLE;
    assign bus.s_axis_divisor_tready  = state_q == IDLE;
    assign bus.m_axis_dout_tvalid     = state_q == DONE;
    assign bus.m_axis_dout_tdata      = dout_q;
    // quo_q starts as the dividend magnitude and shifts out MSB-first as quotient bits shift in
    assign shifted = {rem_q, quo_q[31]};
    assign diff    = shifted - {2'b00, dvs_q};
    assign q_fix   = q_neg_q ? -quo_q : quo_q;
    assign r_fix   = r_neg_q ? -rem_q[31:0] : rem_q[31:0];
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        dz_d    = dz_q;
        dout_d  = dout_q;
        case (state_q)
            IDLE: if (accept) begin
                quo_d   = SIGNED && dvd_in[31] ? -dvd_in : dvd_in;
                dvs_d   = SIGNED && dvs_in[31] ? -dvs_in : dvs_in;
                rem_d   = '0;
                cnt_d   = '0;
                q_neg_d = SIGNED && (dvd_in[31] ^ dvs_in[31]);
                r_neg_d = SIGNED && dvd_in[31];
                dz_d    = dvs_in == '0;
`ifdef DIV_ZERO_BYPASS_EN
                state_d = dz_d ? DONE : BUSY;
                if (dz_d) dout_d = {32'hFFFF_FFFF, dvd_in};
`else
                state_d = BUSY;
`endif
            end
            BUSY: begin
                rem_d   = diff[33] ? shifted[32:0] : diff[32:0];
                quo_d   = {quo_q[30:0], ~diff[33]};
                cnt_d   = cnt_q + 5'd1;
                state_d = cnt_q == 5'd31 ? FIX : BUSY;
            end
            // a zero divisor leaves the dividend magnitude as remainder, so only q is forced
            FIX: begin
                dout_d  = {dz_q ? 32'hFFFF_FFFF : q_fix, r_fix};
                state_d = DONE;
            end
            DONE: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dz_q    <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            dz_q    <= dz_d;
            dout_q  <= dout_d;
        end
    end
endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: signed and unsigned divider instances driven with the same directed vectors.
module tb_div_iter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    div_iter_if bs();
    div_iter_if bu();
    div_iter #(.SIGNED(1'b1)) u_s (.clk(clk), .reset(reset), .bus(bs.slave));
    div_iter #(.SIGNED(1'b0)) u_u (.clk(clk), .reset(reset), .bus(bu.slave));
`ifdef DIV_ZERO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] es;
        logic [63:0] eu;
    } vec_t;
    vec_t v[12];
    int total = 0;
    int bad = 0;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask
    task automatic drive(input logic va, input logic vb, input logic [31:0] a, input logic [31:0] b);
        bs.s_axis_dividend_tvalid = va;
        bs.s_axis_divisor_tvalid  = vb;
        bs.s_axis_dividend_tdata  = a;
        bs.s_axis_divisor_tdata   = b;
        bu.s_axis_dividend_tvalid = va;
        bu.s_axis_divisor_tvalid  = vb;
        bu.s_axis_dividend_tdata  = a;
        bu.s_axis_divisor_tdata   = b;
    endtask
    function automatic logic all_rdy();
        return bs.s_axis_dividend_tready & bs.s_axis_divisor_tready &
               bu.s_axis_dividend_tready & bu.s_axis_divisor_tready;
    endfunction
    function automatic logic any_rdy();
        return bs.s_axis_dividend_tready | bs.s_axis_divisor_tready |
               bu.s_axis_dividend_tready | bu.s_axis_divisor_tready;
    endfunction
    task automatic op(input logic [31:0] a, input logic [31:0] b, input int el,
                      output logic [63:0] ds, output logic [63:0] du,
                      output int ls, output int lu, output int np, output int rb);
        @(negedge clk);
        drive(1'b1, 1'b1, a, b);
        @(posedge clk);
        #1 drive(1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0BAD_F00D);
        ls = -1; lu = -1; np = 0; rb = 0; ds = '0; du = '0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (bs.m_axis_dout_tvalid) begin
                np++;
                if (ls < 0) begin ls = n; ds = bs.m_axis_dout_tdata; end
            end
            if (bu.m_axis_dout_tvalid) begin
                np++;
                if (lu < 0) begin lu = n; du = bu.m_axis_dout_tdata; end
            end
            if (n <= el && any_rdy()) rb++;
            if (n == el + 1 && !all_rdy()) rb++;
        end
    endtask
    task automatic full_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] es, input logic [63:0] eu);
        logic [63:0] ds, du;
        int ls, lu, np, rb, el;
        el = (BYP && b == 32'd0) ? 1 : 34;
        op(a, b, el, ds, du, ls, lu, np, rb);
        chk({nm, "_sdata"}, ds, es);
        chk({nm, "_udata"}, du, eu);
        chk({nm, "_slat"}, 64'(ls), 64'(el));
        chk({nm, "_ulat"}, 64'(lu), 64'(el));
        chk({nm, "_pulses"}, 64'(np), 64'd2);
        chk({nm, "_ready"}, 64'(rb), 64'd0);
    endtask
    initial begin
        int np, c0, c1;
        v[0]  = '{32'd100,        32'd7,          64'h0000000E_00000002, 64'h0000000E_00000002};
        v[1]  = '{32'hFFFFFFF9,   32'd2,          64'hFFFFFFFD_FFFFFFFF, 64'h7FFFFFFC_00000001};
        v[2]  = '{32'd7,          32'hFFFFFFFE,   64'hFFFFFFFD_00000001, 64'h00000000_00000007};
        v[3]  = '{32'h80000000,   32'hFFFFFFFF,   64'h80000000_00000000, 64'h00000000_80000000};
        v[4]  = '{32'hFFFFFFFF,   32'd1,          64'hFFFFFFFF_00000000, 64'hFFFFFFFF_00000000};
        v[5]  = '{32'h12345678,   32'd0,          64'hFFFFFFFF_12345678, 64'hFFFFFFFF_12345678};
        v[6]  = '{32'h80000000,   32'd0,          64'hFFFFFFFF_80000000, 64'hFFFFFFFF_80000000};
        v[7]  = '{32'hFFFFFFF9,   32'd0,          64'hFFFFFFFF_FFFFFFF9, 64'hFFFFFFFF_FFFFFFF9};
        v[8]  = '{32'd0,          32'd5,          64'h00000000_00000000, 64'h00000000_00000000};
        v[9]  = '{32'hFFFFFF9C,   32'hFFFFFFF9,   64'h0000000E_FFFFFFFE, 64'h00000000_FFFFFF9C};
        v[10] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   64'h00000001_00000000, 64'h00000001_00000000};
        v[11] = '{32'h12345678,   32'd1000,       64'h0004A90B_00000380, 64'h0004A90B_00000380};
        drive(1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(all_rdy()), 64'd1);
        chk("rst_valid", 64'(bs.m_axis_dout_tvalid | bu.m_axis_dout_tvalid), 64'd0);
        chk("rst_sdata", bs.m_axis_dout_tdata, 64'd0);
        chk("rst_udata", bu.m_axis_dout_tdata, 64'd0);
        reset = 1'b0;
        for (int i = 0; i < 12; i++)
            full_op($sformatf("v%0d", i), v[i].a, v[i].b, v[i].es, v[i].eu);
        // a lone dividend valid must not be accepted
        @(negedge clk);
        drive(1'b1, 1'b0, 32'd100, 32'd7);
        np = 0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (!all_rdy()) np++;
            if (bs.m_axis_dout_tvalid | bu.m_axis_dout_tvalid) np++;
        end
        chk("lone_valid_idle", 64'(np), 64'd0);
        full_op("lone_then_pair", 32'd100, 32'd7, 64'h0000000E_00000002, 64'h0000000E_00000002);
        // reset in cycle 10 abandons the division
        @(negedge clk);
        drive(1'b1, 1'b1, 32'd100, 32'd7);
        @(posedge clk);
        #1 drive(1'b0, 1'b0, '0, '0);
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("midrst_ready", 64'(all_rdy()), 64'd1);
        chk("midrst_valid", 64'(bs.m_axis_dout_tvalid | bu.m_axis_dout_tvalid), 64'd0);
        chk("midrst_sdata", bs.m_axis_dout_tdata, 64'd0);
        chk("midrst_udata", bu.m_axis_dout_tdata, 64'd0);
        reset = 1'b0;
        np = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bs.m_axis_dout_tvalid | bu.m_axis_dout_tvalid) np++;
        end
        chk("midrst_no_pulse", 64'(np), 64'd0);
        full_op("after_rst", 32'd100, 32'd7, 64'h0000000E_00000002, 64'h0000000E_00000002);
        // valids held continuously: accepts in cycles 0 and 35
        @(negedge clk);
        drive(1'b1, 1'b1, 32'd100, 32'd7);
        np = 0; c0 = -1; c1 = -1;
        for (int n = 1; n <= 72; n++) begin
            @(negedge clk);
            if (bs.m_axis_dout_tvalid) begin
                if (np == 0) c0 = n;
                else if (np == 1) c1 = n;
                np++;
            end
        end
        drive(1'b0, 1'b0, '0, '0);
        chk("b2b_pulses", 64'(np), 64'd2);
        chk("b2b_first", 64'(c0), 64'd34);
        chk("b2b_second", 64'(c1), 64'd69);
        chk("b2b_data", bs.m_axis_dout_tdata, 64'h0000000E_00000002);
        repeat (40) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/div_iter.md
# div_iter

Iterative 32-bit radix-2 restoring divider and the responder side of the divider AXI-stream handshake used by the EXE-stage HI/LO unit. It accepts a dividend and a divisor over two slave channels and returns a 64-bit result on one master channel: quotient in [63:32] and remainder in [31:0]. The HI/LO unit instantiates it twice, once as `div` (signed) and once as `divu` (unsigned). It replaces vendor divider IP with the same port shape.

## Interface
- SIGNED, 1, 1 = two's-complement division (`div`); 0 = unsigned division (`divu`).
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; clears the block to IDLE immediately.
- s_axis_dividend_tvalid  in  1  dividend valid.
- s_axis_dividend_tready  out  1  dividend ready; high exactly when state is IDLE.
- s_axis_dividend_tdata  in  32  dividend.
- s_axis_divisor_tvalid  in  1  divisor valid.
- s_axis_divisor_tready  out  1  divisor ready; identical to s_axis_dividend_tready.
- s_axis_divisor_tdata  in  32  divisor.
- m_axis_dout_tvalid  out  1  result valid; one-cycle pulse, no back-pressure.
- m_axis_dout_tdata  out  64  {quotient, remainder}; held stable from the pulse until the next accept.

## Operation
- States: IDLE, BUSY, FIX, DONE.
- IDLE: both treadys are high. Accept occurs only when dividend_tvalid and divisor_tvalid are both high in the same cycle. A single valid is ignored and nothing is latched.
- On accept:
  - Latch the operand magnitudes. When SIGNED=1, take the absolute value as an unsigned 32-bit number, so |0x80000000| = 0x80000000.
  - Latch the sign flags: q_neg = sign(dividend) XOR sign(divisor); r_neg = sign(dividend).
  - Clear the 5-bit iteration counter and go to BUSY.
- BUSY: perform one restoring step per cycle on a 33-bit partial remainder, shifting one quotient bit in per cycle, MSB first. After 32 steps (counter wraps 31 -> 0), go to FIX.
- FIX: when SIGNED=1, negate the quotient if q_neg and negate the remainder if r_neg. Register the result into m_axis_dout_tdata and go to DONE.
- DONE: m_axis_dout_tvalid=1 for this single cycle, then go to IDLE.
- Arithmetic rules:
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - Signed 0x80000000 / 0xFFFFFFFF gives q=0x80000000, r=0 (wraps, no trap).
- Divide by zero (divisor == 0): result is always q=0xFFFFFFFF, r=dividend, for both SIGNED values.
- Reset values: state IDLE, both treadys 1, m_axis_dout_tvalid 0, m_axis_dout_tdata 0, counter 0.
- Reset mid-operation: the in-flight division is abandoned and no tvalid pulse is produced. The block accepts again in the first cycle after reset deasserts.
- tdata inputs are don't-care outside the accept cycle. The initiator holds tvalid high until accept.

## Timing
- Accept cycle = cycle 0. BUSY occupies cycles 1-32, FIX cycle 33, DONE cycle 34: m_axis_dout_tvalid is high in cycle 34 only.
- Treadys are low in cycles 1-34 and high again in cycle 35.
- Minimum accept-to-accept spacing is 35 cycles.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.

## Configuration
- DIV_ZERO_BYPASS_EN defined: on accept with divisor == 0, go directly to DONE with the divide-by-zero result. m_axis_dout_tvalid is high in cycle 1 and tready is high in cycle 2.
- DIV_ZERO_BYPASS_EN undefined: divide by zero takes the full 34-cycle path. FIX forces the divide-by-zero result.

## Test plan
- Unsigned (SIGNED=0), 100 / 7 -> tvalid in cycle 34 only, tdata=0x0000000E_00000002. Treadys are low in cycles 1-34.
- Signed, 0xFFFFFFF9 (-7) / 2 -> tdata=0xFFFFFFFD_FFFFFFFF. Signed, 7 / 0xFFFFFFFE -> tdata=0xFFFFFFFD_00000001.
- Signed 0x80000000 / 0xFFFFFFFF -> tdata=0x80000000_00000000. Unsigned 0xFFFFFFFF / 1 -> tdata=0xFFFFFFFF_00000000.
- Divisor 0, dividend 0x12345678:
  - Without the macro -> tvalid in cycle 34, tdata=0xFFFFFFFF_12345678.
  - With DIV_ZERO_BYPASS_EN -> same tdata in cycle 1.
- Dividend_tvalid alone held for 5 cycles -> no accept and treadys stay high. Raising divisor_tvalid -> accept in that cycle.
- Assert reset in cycle 10 of an operation -> no tvalid pulse, tdata=0. After release, 100 / 7 completes correctly with tvalid 34 cycles after its accept.
- Back-to-back: valids held high continuously -> accepts in cycles 0 and 35, tvalid pulses in cycles 34 and 69.
